camera_control_multi: RTL and testbench
=======================================

Name: camera_control_multi

Overview:
Parametrised successor to the two-row camera exposure/readout controller. It sequences one exposure followed by ADC readout of NUM_ROWS amplifier rows. Exposure time is adjustable with saturation limits. Adds a continuous (back-to-back frame) mode, a synchronous abort, and busy/frame_done status. It sits between the user buttons/host and the sensor array and ADC.

Parameters:
NUM_ROWS, 2, number of amplifier rows read per frame (>=1)
EXP_W, 5, exposure time/counter width in bits
EXP_MIN, 2, lowest settable exposure time in clock cycles (>=1)
EXP_MAX, 30, highest settable exposure time (<= 2^EXP_W-1)
EXP_RESET, 15, exposure time loaded at reset
ADC_CYCLES, 3, cycles each row's nre is held low (>=1)
ADC_PULSE_AT, 1, 0-based cycle within the row window where adc is high (< ADC_CYCLES)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
init  in  1  start a frame (sampled in IDLE)
exp_inc  in  1  increment exposure time, one step per cycle held
exp_dec  in  1  decrement exposure time, one step per cycle held
continuous  in  1  1 = start the next frame immediately after frame_done
abort  in  1  synchronous abort of the current frame
nre  out  NUM_ROWS  row read enables, active-low; bit r selects row r
adc  out  1  ADC sample strobe
expose  out  1  sensor exposing
erase  out  1  sensor erase (charge clear)
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse at end of a complete frame
exp_time  out  EXP_W  current exposure setting

Behaviour:
- Reset (async, immediate): state IDLE; nre all 1; adc 0; expose 0; erase 1; busy 0; frame_done 0; exp_time EXP_RESET; all counters 0.
- All outputs are registered and consistent with the current state. There are no combinational paths from inputs to outputs.
- States: IDLE, CAPTURE, CONVERT, DONE.
- IDLE:
  - Outputs: erase 1, expose 0, nre all 1, adc 0.
  - init=1 -> CAPTURE next cycle. init has priority over exp_inc/exp_dec.
  - Otherwise exp_inc=1 and exp_dec=0: exp_time+1 if exp_time<EXP_MAX, else hold.
  - exp_dec=1 and exp_inc=0: exp_time-1 if exp_time>EXP_MIN, else hold.
  - Both or neither: no change.
  - exp_inc/exp_dec are ignored outside IDLE.
- CAPTURE:
  - Outputs: expose 1, erase 0.
  - exp_time is latched on entry. Expose stays high for exactly that many cycles, then the state goes to CONVERT with row index 0.
- CONVERT, per row r = 0..NUM_ROWS-1:
  - Window of ADC_CYCLES cycles: nre[r]=0 and all other bits 1; adc=1 only in window cycle ADC_PULSE_AT.
  - After the window: one gap cycle with all nre 1 and adc 0.
  - After the gap of row NUM_ROWS-1 -> DONE.
  - Rows are always read in ascending order. At most one nre bit is low in any cycle.
- DONE (1 cycle):
  - Outputs: frame_done 1, erase 1, busy 1.
  - Next state: CAPTURE if continuous=1 (sampled in DONE), else IDLE.
- Frame length from init sample to frame_done inclusive: exp_time + NUM_ROWS*(ADC_CYCLES+1) + 1 cycles.
- abort=1 in CAPTURE or CONVERT:
  - Next cycle: IDLE; nre all 1; adc 0; expose 0; erase 1; no frame_done.
  - abort is ignored in IDLE and DONE.
- Counter widths: the exposure counter is EXP_W bits and never wraps, because the compare is against the latched exp_time. Row index width is clog2(NUM_ROWS) with a minimum of 1.
- Illegal parameter combinations (EXP_MIN>EXP_MAX, EXP_RESET outside [EXP_MIN, EXP_MAX], ADC_PULSE_AT>=ADC_CYCLES) are flagged by an elaboration-time check.

Test Plan:
- Default parameters, reset pulse mid-run -> outputs immediately at reset values; exp_time=15.
- init one cycle, defaults -> the following are observed, with frame_done 24 cycles after init sampled, then IDLE:
  - expose high exactly 15 cycles;
  - nre=2'b10 for 3 cycles, adc high in the 2nd of those;
  - 1 gap cycle;
  - nre=2'b01 for 3 cycles, adc high in the 2nd;
  - 1 gap cycle;
  - frame_done for 1 cycle.
- Exposure adjustment in IDLE:
  - exp_inc held 20 cycles from 15 -> exp_time saturates at 30;
  - exp_dec held 40 cycles -> saturates at 2;
  - both held -> unchanged;
  - exp_inc held during CAPTURE -> unchanged.
- continuous=1, init once -> back-to-back frames; erase high for only the 1 DONE cycle between exposures; frame_done pulses every 24 cycles.
- abort during the nre[1] window -> next cycle IDLE, nre=2'b11, adc 0, erase 1, no frame_done; a fresh init then runs a full frame.
- NUM_ROWS=4, ADC_CYCLES=2, ADC_PULSE_AT=0, exp_time 5 -> nre steps 1110, 1101, 1011, 0111, each for 2 cycles with a gap cycle after each; adc on the first cycle of each window; frame_done 5+12+1=18 cycles after init.

Source files
------------

// File: rtl/camera_control_multi_if.sv
// Host/sensor-side bundle for camera_control_multi: user controls in, sensor/ADC strobes out.
interface camera_control_multi_if #(
  parameter int unsigned NUM_ROWS = 2,
  parameter int unsigned EXP_W    = 5
) ();

  // Host/user controls
  logic                init;
  logic                exp_inc;
  logic                exp_dec;
  logic                continuous;
  logic                abort;

  // Sensor/ADC drive and status
  logic [NUM_ROWS-1:0] nre;
  logic                adc;
  logic                expose;
  logic                erase;
  logic                busy;
  logic                frame_done;
  logic [EXP_W-1:0]    exp_time;

  // Host side: drives the controls, observes status
  modport master (
    output init, exp_inc, exp_dec, continuous, abort,
    input  nre, adc, expose, erase, busy, frame_done, exp_time
  );

  // Controller side
  modport slave (
    input  init, exp_inc, exp_dec, continuous, abort,
    output nre, adc, expose, erase, busy, frame_done, exp_time
  );

endinterface

// File: rtl/camera_control_multi.sv
// Exposure + multi-row readout sequencer. One exposure of exp_time cycles, then each row gets an
// ADC_CYCLES-long nre window (with one adc strobe) followed by a gap cycle, then a one-cycle DONE.
// Every output is a flop loaded from the decoded next state, so outputs never see inputs
// combinationally.
module camera_control_multi #(
  parameter int unsigned NUM_ROWS     = 2,
  parameter int unsigned EXP_W        = 5,
  parameter int unsigned EXP_MIN      = 2,
  parameter int unsigned EXP_MAX      = 30,
  parameter int unsigned EXP_RESET    = 15,
  parameter int unsigned ADC_CYCLES   = 3,
  parameter int unsigned ADC_PULSE_AT = 1
) (
  input logic                   clk,
  input logic                   reset,
  camera_control_multi_if.slave bus
);

  localparam int unsigned RowW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  // Window counter runs 0..ADC_CYCLES; the value ADC_CYCLES is the gap cycle.
  localparam int unsigned WinW = $clog2(ADC_CYCLES + 1);

  localparam logic [EXP_W-1:0] ExpMin   = EXP_W'(EXP_MIN);
  localparam logic [EXP_W-1:0] ExpMax   = EXP_W'(EXP_MAX);
  localparam logic [EXP_W-1:0] ExpReset = EXP_W'(EXP_RESET);
  localparam logic [EXP_W-1:0] ExpOne   = EXP_W'(1);
  localparam logic [RowW-1:0]  LastRow  = RowW'(NUM_ROWS - 1);
  localparam logic [RowW-1:0]  RowOne   = RowW'(1);
  localparam logic [WinW-1:0]  WinGap   = WinW'(ADC_CYCLES);
  localparam logic [WinW-1:0]  WinPulse = WinW'(ADC_PULSE_AT);
  localparam logic [WinW-1:0]  WinOne   = WinW'(1);

  // Reject parameter sets that would make the sequence meaningless.
  if (NUM_ROWS < 1 || ADC_CYCLES < 1 || EXP_MIN < 1) begin : gen_bad_sizes
    $error("camera_control_multi: NUM_ROWS, ADC_CYCLES and EXP_MIN must be >= 1");
  end
  if (EXP_MIN > EXP_MAX || EXP_MAX > (2 ** EXP_W) - 1) begin : gen_bad_exp_range
    $error("camera_control_multi: need EXP_MIN <= EXP_MAX <= 2^EXP_W-1");
  end
  if (EXP_RESET < EXP_MIN || EXP_RESET > EXP_MAX) begin : gen_bad_exp_reset
    $error("camera_control_multi: EXP_RESET must lie in [EXP_MIN, EXP_MAX]");
  end
  if (ADC_PULSE_AT >= ADC_CYCLES) begin : gen_bad_pulse
    $error("camera_control_multi: ADC_PULSE_AT must be < ADC_CYCLES");
  end

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StConvert,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [EXP_W-1:0]    exp_time_q, exp_time_d;
  logic [EXP_W-1:0]    exp_lat_q, exp_lat_d;
  logic [EXP_W-1:0]    exp_cnt_q, exp_cnt_d;
  logic [RowW-1:0]     row_q, row_d;
  logic [WinW-1:0]     win_q, win_d;

  logic [NUM_ROWS-1:0] nre_q, nre_d;
  logic                adc_q, adc_d;
  logic                expose_q, expose_d;
  logic                erase_q, erase_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;

  // Next-state, exposure setting and sequencing counters.
  always_comb begin
    state_d    = state_q;
    exp_time_d = exp_time_q;
    exp_lat_d  = exp_lat_q;
    exp_cnt_d  = exp_cnt_q;
    row_d      = row_q;
    win_d      = win_q;
    unique case (state_q)
      StIdle: begin
        if (bus.init) begin
          state_d   = StCapture;
          exp_lat_d = exp_time_q;
          exp_cnt_d = '0;
        end else if (bus.exp_inc && !bus.exp_dec) begin
          if (exp_time_q < ExpMax) exp_time_d = exp_time_q + ExpOne;
        end else if (bus.exp_dec && !bus.exp_inc) begin
          if (exp_time_q > ExpMin) exp_time_d = exp_time_q - ExpOne;
        end
      end
      StCapture: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (exp_cnt_q == exp_lat_q - ExpOne) begin
          // Counter started at 0 on entry, so this is the last exposure cycle.
          state_d = StConvert;
          row_d   = '0;
          win_d   = '0;
        end else begin
          exp_cnt_d = exp_cnt_q + ExpOne;
        end
      end
      StConvert: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (win_q == WinGap) begin
          win_d = '0;
          if (row_q == LastRow) begin
            state_d = StDone;
          end else begin
            row_d = row_q + RowOne;
          end
        end else begin
          win_d = win_q + WinOne;
        end
      end
      StDone: begin
        if (bus.continuous) begin
          state_d   = StCapture;
          exp_lat_d = exp_time_q;
          exp_cnt_d = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Decode the outputs for the state being entered so they can be registered.
  always_comb begin
    nre_d        = '1;
    adc_d        = 1'b0;
    expose_d     = (state_d == StCapture);
    erase_d      = (state_d == StIdle) || (state_d == StDone);
    busy_d       = (state_d != StIdle);
    frame_done_d = (state_d == StDone);
    if (state_d == StConvert && win_d != WinGap) begin
      for (int unsigned r = 0; r < NUM_ROWS; r++) begin
        nre_d[r] = (row_d != RowW'(r));
      end
      adc_d = (win_d == WinPulse);
    end
  end

  // State, counter and exposure-setting registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      exp_time_q <= ExpReset;
      exp_lat_q  <= '0;
      exp_cnt_q  <= '0;
      row_q      <= '0;
      win_q      <= '0;
    end else begin
      state_q    <= state_d;
      exp_time_q <= exp_time_d;
      exp_lat_q  <= exp_lat_d;
      exp_cnt_q  <= exp_cnt_d;
      row_q      <= row_d;
      win_q      <= win_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nre_q        <= '1;
      adc_q        <= 1'b0;
      expose_q     <= 1'b0;
      erase_q      <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      nre_q        <= nre_d;
      adc_q        <= adc_d;
      expose_q     <= expose_d;
      erase_q      <= erase_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.nre        = nre_q;
  assign bus.adc        = adc_q;
  assign bus.expose     = expose_q;
  assign bus.erase      = erase_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.exp_time   = exp_time_q;

endmodule

// File: tb/tb_camera_control_multi.sv
// Bench for camera_control_multi: default-parameter instance plus a 4-row instance, checked
// cycle by cycle against a frame-timeline model.
module tb_camera_control_multi;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  camera_control_multi_if #(.NUM_ROWS(2), .EXP_W(5)) bus0 ();
  camera_control_multi_if #(.NUM_ROWS(4), .EXP_W(5)) bus1 ();

  camera_control_multi #(
    .NUM_ROWS(2), .EXP_W(5), .EXP_MIN(2), .EXP_MAX(30), .EXP_RESET(15),
    .ADC_CYCLES(3), .ADC_PULSE_AT(1)
  ) dut0 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus0)
  );

  camera_control_multi #(
    .NUM_ROWS(4), .EXP_W(5), .EXP_MIN(2), .EXP_MAX(30), .EXP_RESET(5),
    .ADC_CYCLES(2), .ADC_PULSE_AT(0)
  ) dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1)
  );

  int n_pass  = 0;
  int n_total = 0;
  int exp_model;  // expected exp_time of dut0

  // Expected {nre[3:0], adc, expose, erase, busy, frame_done} in cycle k of a frame (k=1 is the
  // cycle after init is sampled); k outside 1..len means idle.
  function automatic logic [8:0] model_out(input int k, input int e, input int rows,
                                           input int ac, input int ap);
    logic [3:0] nre;
    logic adc, expose, erase, busy, fd;
    int len, j, row, w;
    len = e + rows * (ac + 1) + 1;
    nre = 4'hF; adc = 0; expose = 0; erase = 1; busy = 0; fd = 0;
    if (k >= 1 && k <= len) begin
      busy = 1;
      if (k <= e) begin
        expose = 1; erase = 0;
      end else if (k == len) begin
        fd = 1;
      end else begin
        erase = 0;
        j = k - e - 1;
        row = j / (ac + 1);
        w = j % (ac + 1);
        if (w < ac) begin
          nre[row] = 1'b0;
          adc = (w == ap);
        end
      end
    end
    return {nre, adc, expose, erase, busy, fd};
  endfunction

  function automatic int frame_len(input int e, input int rows, input int ac);
    return e + rows * (ac + 1) + 1;
  endfunction

  function automatic int sat_step(input int e, input logic inc, input logic dec);
    if (inc && !dec && e < 30) return e + 1;
    if (dec && !inc && e > 2) return e - 1;
    return e;
  endfunction

  function automatic logic [8:0] obs0();
    return {2'b11, bus0.nre, bus0.adc, bus0.expose, bus0.erase, bus0.busy, bus0.frame_done};
  endfunction

  function automatic logic [8:0] obs1();
    return {bus1.nre, bus1.adc, bus1.expose, bus1.erase, bus1.busy, bus1.frame_done};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walk dut0's exposure setting to target while idle (stimulus only).
  task automatic set_exp(input int target);
    while (exp_model != target) begin
      bus0.exp_inc = (exp_model < target);
      bus0.exp_dec = (exp_model > target);
      step();
      exp_model = sat_step(exp_model, bus0.exp_inc, bus0.exp_dec);
    end
    bus0.exp_inc = 0;
    bus0.exp_dec = 0;
  endtask

  task automatic test_reset();
    logic [8:0] exp;
    reset = 1'b1;
    #3;
    exp = model_out(0, 1, 2, 3, 1);
    n_total++;
    if (obs0() !== exp) $display("FAIL reset_outputs0: got %b expected %b", obs0(), exp);
    else n_pass++;
    n_total++;
    if (bus0.exp_time !== 5'd15) $display("FAIL reset_exp0: got %0d expected 15", bus0.exp_time);
    else n_pass++;
    n_total++;
    if (obs1() !== exp) $display("FAIL reset_outputs1: got %b expected %b", obs1(), exp);
    else n_pass++;
    n_total++;
    if (bus1.exp_time !== 5'd5) $display("FAIL reset_exp1: got %0d expected 5", bus1.exp_time);
    else n_pass++;
    step();
    reset = 1'b0;
    exp_model = 15;
    step();
    n_total++;
    if (obs0() !== exp) $display("FAIL idle_after_reset: got %b expected %b", obs0(), exp);
    else n_pass++;
  endtask

  task automatic test_exp_adjust();
    for (int phase = 0; phase < 4; phase++) begin
      int cycles;
      cycles = (phase == 0) ? 20 : (phase == 1) ? 40 : (phase == 2) ? 10 : 60;
      for (int i = 0; i < cycles; i++) begin
        unique case (phase)
          0: begin bus0.exp_inc = 1; bus0.exp_dec = 0; end
          1: begin bus0.exp_inc = 0; bus0.exp_dec = 1; end
          2: begin bus0.exp_inc = 1; bus0.exp_dec = 1; end
          default: begin bus0.exp_inc = 1'($urandom); bus0.exp_dec = 1'($urandom); end
        endcase
        step();
        exp_model = sat_step(exp_model, bus0.exp_inc, bus0.exp_dec);
        n_total++;
        if (bus0.exp_time !== 5'(exp_model))
          $display("FAIL exp_adjust phase %0d cycle %0d: got %0d expected %0d",
                   phase, i, bus0.exp_time, exp_model);
        else n_pass++;
      end
      if (phase == 0) begin
        n_total++;
        if (bus0.exp_time !== 5'd30) $display("FAIL exp_sat_high: got %0d expected 30",
                                              bus0.exp_time);
        else n_pass++;
      end
      if (phase == 1) begin
        n_total++;
        if (bus0.exp_time !== 5'd2) $display("FAIL exp_sat_low: got %0d expected 2",
                                             bus0.exp_time);
        else n_pass++;
      end
    end
    bus0.exp_inc = 0;
    bus0.exp_dec = 0;
  endtask

  // Default frame with exp_inc held throughout: init wins, and CAPTURE ignores exp_inc.
  task automatic test_single_frame();
    int len;
    logic [8:0] exp;
    set_exp(15);
    len = frame_len(15, 2, 3);
    bus0.init = 1;
    bus0.exp_inc = 1;
    step();
    bus0.init = 0;
    for (int k = 1; k <= len + 1; k++) begin
      if (k == len + 1) bus0.exp_inc = 0;
      exp = model_out(k, 15, 2, 3, 1);
      n_total++;
      if (obs0() !== exp) $display("FAIL single_frame cycle %0d: got %b expected %b",
                                   k, obs0(), exp);
      else n_pass++;
      if (k == len) bus0.exp_inc = 0;
      if (k <= len) step();
    end
    n_total++;
    if (bus0.exp_time !== 5'd15) $display("FAIL exp_during_frame: got %0d expected 15",
                                          bus0.exp_time);
    else n_pass++;
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 4; f++) begin
      int e, len;
      logic [8:0] exp;
      e = int'($urandom_range(30, 2));
      set_exp(e);
      len = frame_len(e, 2, 3);
      bus0.init = 1;
      step();
      bus0.init = 0;
      for (int k = 1; k <= len + 1; k++) begin
        exp = model_out(k, e, 2, 3, 1);
        n_total++;
        if (obs0() !== exp) $display("FAIL random_frame e=%0d cycle %0d: got %b expected %b",
                                     e, k, obs0(), exp);
        else n_pass++;
        bus0.exp_inc = (k < len) ? 1'($urandom) : 1'b0;
        bus0.exp_dec = (k < len) ? 1'($urandom) : 1'b0;
        if (k <= len) step();
      end
      n_total++;
      if (bus0.exp_time !== 5'(e)) $display("FAIL random_frame_exp: got %0d expected %0d",
                                            bus0.exp_time, e);
      else n_pass++;
    end
  endtask

  task automatic test_continuous();
    int len;
    logic [8:0] exp;
    set_exp(15);
    len = frame_len(15, 2, 3);
    bus0.continuous = 1;
    bus0.init = 1;
    step();
    bus0.init = 0;
    for (int k = 1; k <= 3 * len + 1; k++) begin
      exp = (k <= 3 * len) ? model_out(((k - 1) % len) + 1, 15, 2, 3, 1) : model_out(0, 1, 2, 3, 1);
      n_total++;
      if (obs0() !== exp) $display("FAIL continuous cycle %0d: got %b expected %b",
                                   k, obs0(), exp);
      else n_pass++;
      if (k == 2 * len + 1) bus0.continuous = 0;
      if (k <= 3 * len) step();
    end
  endtask

  task automatic test_abort();
    int len;
    logic [8:0] exp;
    logic [8:0] idle;
    idle = model_out(0, 1, 2, 3, 1);
    for (int t = 0; t < 4; t++) begin
      int e, ab;
      e = (t == 0) ? 15 : int'($urandom_range(8, 2));
      set_exp(e);
      len = frame_len(e, 2, 3);
      // Trial 0 aborts mid nre[1] window; others at a random busy cycle before DONE.
      ab = (t == 0) ? e + 6 : int'($urandom_range(len - 1, 1));
      bus0.init = 1;
      step();
      bus0.init = 0;
      for (int k = 1; k <= ab; k++) begin
        exp = model_out(k, e, 2, 3, 1);
        n_total++;
        if (obs0() !== exp) $display("FAIL abort_pre e=%0d cycle %0d: got %b expected %b",
                                     e, k, obs0(), exp);
        else n_pass++;
        if (k == ab) bus0.abort = 1;
        step();
      end
      bus0.abort = 0;
      for (int i = 0; i < 2; i++) begin
        n_total++;
        if (obs0() !== idle) $display("FAIL abort_idle at %0d +%0d: got %b expected %b",
                                      ab, i, obs0(), idle);
        else n_pass++;
        step();
      end
    end
    // Fresh frame: abort in IDLE is ignored alongside init, and in DONE with continuous set.
    set_exp(15);
    len = frame_len(15, 2, 3);
    bus0.init = 1;
    bus0.abort = 1;
    step();
    bus0.init = 0;
    bus0.abort = 0;
    for (int k = 1; k <= len; k++) begin
      exp = model_out(k, 15, 2, 3, 1);
      n_total++;
      if (obs0() !== exp) $display("FAIL post_abort_frame cycle %0d: got %b expected %b",
                                   k, obs0(), exp);
      else n_pass++;
      if (k == len) begin
        bus0.abort = 1;
        bus0.continuous = 1;
      end
      step();
    end
    bus0.continuous = 0;
    exp = model_out(1, 15, 2, 3, 1);
    n_total++;
    if (obs0() !== exp) $display("FAIL abort_in_done: got %b expected %b", obs0(), exp);
    else n_pass++;
    step();
    bus0.abort = 0;
    n_total++;
    if (obs0() !== idle) $display("FAIL abort_first_capture: got %b expected %b", obs0(), idle);
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    logic [8:0] idle;
    idle = model_out(0, 1, 2, 3, 1);
    set_exp(22);
    bus0.init = 1;
    step();
    bus0.init = 0;
    repeat ($urandom_range(20, 1)) step();
    #2 reset = 1'b1;
    #1;
    n_total++;
    if (obs0() !== idle) $display("FAIL reset_midrun_outputs: got %b expected %b", obs0(), idle);
    else n_pass++;
    n_total++;
    if (bus0.exp_time !== 5'd15) $display("FAIL reset_midrun_exp: got %0d expected 15",
                                          bus0.exp_time);
    else n_pass++;
    exp_model = 15;
    step();
    reset = 1'b0;
    step();
    n_total++;
    if (obs0() !== idle) $display("FAIL reset_midrun_idle: got %b expected %b", obs0(), idle);
    else n_pass++;
  endtask

  task automatic test_four_rows();
    int len;
    logic [8:0] exp;
    len = frame_len(5, 4, 2);
    bus1.init = 1;
    step();
    bus1.init = 0;
    for (int k = 1; k <= len + 1; k++) begin
      exp = model_out(k, 5, 4, 2, 0);
      n_total++;
      if (obs1() !== exp) $display("FAIL four_rows cycle %0d: got %b expected %b",
                                   k, obs1(), exp);
      else n_pass++;
      if (k <= len) step();
    end
  endtask

  initial begin
    reset = 1'b1;
    bus0.init = 0; bus0.exp_inc = 0; bus0.exp_dec = 0; bus0.continuous = 0; bus0.abort = 0;
    bus1.init = 0; bus1.exp_inc = 0; bus1.exp_dec = 0; bus1.continuous = 0; bus1.abort = 0;
    exp_model = 15;
    test_reset();
    test_exp_adjust();
    test_single_frame();
    test_random_frames();
    test_continuous();
    test_abort();
    test_four_rows();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
